gray_cnt: RTL



---
 rtl/gray_cnt_pkg.sv | 21 ++
 rtl/gray_cnt_bin2gray.sv | 14 +
 rtl/gray_cnt.sv | 77 +++++++
 3 files changed

// File: rtl/gray_cnt_pkg.sv
// Shared constants and types for the up/down Gray counter slice.
package gray_cnt_pkg;

  localparam int BW_DATA_DEF = 3;
  localparam int CLKFREQ     = 100_000_000;

  // Resolved per-edge operation after priority (reset is handled in the register).
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } cnt_op_e;

  // Status pulses that accompany each count update.
  typedef struct packed {
    logic step;
    logic wrap;
  } cnt_flags_t;

endpackage

// File: rtl/gray_cnt_bin2gray.sv
// Combinational binary-to-Gray converter, b ^ (b >> 1).
module gray_cnt_bin2gray #(
  parameter int BW_DATA = gray_cnt_pkg::BW_DATA_DEF
) (
  input  logic [BW_DATA-1:0] bin,
  output logic [BW_DATA-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/gray_cnt.sv
// Up/down binary counter with a registered, cycle-aligned Gray output
// and one-cycle step/wrap status pulses.
module gray_cnt
  import gray_cnt_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_dir,
  input  logic               i_load,
  input  logic [BW_DATA-1:0] i_load_val,
  output logic [BW_DATA-1:0] o_binary,
  output logic [BW_DATA-1:0] o_gray,
  output logic               o_step,
  output logic               o_wrap
);

  cnt_op_e            op;
  logic [BW_DATA-1:0] bin_q;
  logic [BW_DATA-1:0] bin_nxt;
  logic [BW_DATA-1:0] gray_nxt;
  cnt_flags_t         flags_q;
  cnt_flags_t         flags_nxt;

  // Priority: load beats enable; direction is sampled on the same edge.
  always_comb begin
    op = OP_HOLD;
    if (i_load)     op = OP_LOAD;
    else if (i_en)  op = i_dir ? OP_UP : OP_DOWN;
  end

  // Next count and status; wrap is detected from the old value at the extremes.
  always_comb begin
    bin_nxt   = bin_q;
    flags_nxt = '0;
    case (op)
      OP_LOAD: bin_nxt = i_load_val;
      OP_UP: begin
        bin_nxt        = bin_q + BW_DATA'(1);
        flags_nxt.step = 1'b1;
        flags_nxt.wrap = &bin_q;
      end
      OP_DOWN: begin
        bin_nxt        = bin_q - BW_DATA'(1);
        flags_nxt.step = 1'b1;
        flags_nxt.wrap = ~|bin_q;
      end
      default: ;
    endcase
  end

  // Gray is derived from the next value so it lands in the same edge as the count.
  gray_cnt_bin2gray #(.BW_DATA(BW_DATA)) u_bin2gray (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // Count, Gray and status registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q   <= '0;
      o_gray  <= '0;
      flags_q <= '0;
    end else begin
      bin_q   <= bin_nxt;
      o_gray  <= gray_nxt;
      flags_q <= flags_nxt;
    end
  end

  assign o_binary = bin_q;
  assign o_step   = flags_q.step;
  assign o_wrap   = flags_q.wrap;

endmodule
